// File: rtl/uart_pkg.sv
// Shared constants and FSM encoding for the 8E1 UART transmitter.
package uart_pkg;

  localparam int CLKS_PER_BIT = 27;
  localparam int DATA_BITS    = 8;
  localparam int FRAME_BITS   = 11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

endpackage

// File: rtl/uart_baud_cnt.sv
// Per-bit cycle counter; o_bit_end marks the last clock of each serial bit.
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT
) (
  input  logic clk_3125,
  input  logic i_rst,
  input  logic i_restart,
  output logic o_bit_end
);

  localparam logic [4:0] LAST = 5'(CLKS_PER_BIT - 1);

  logic [4:0] r_cnt;

  always_ff @(posedge clk_3125) begin
    if (i_rst || i_restart) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 5'd1;
    end
  end

  assign o_bit_end = (r_cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: start, 8 data bits MSB first, even parity, one stop bit,
// with a one-entry holding register so the next byte can queue behind a frame.
module uart_tx #(
  parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT
) (
  input  logic       clk_3125,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done,
  output logic [2:0] state
);

  import uart_pkg::*;

  state_t     r_state, w_state_next;
  logic [7:0] r_hold, r_shift, w_shift_next;
  logic [2:0] r_bit_cnt, w_bit_cnt_next;
  logic       r_hold_full, r_parity, w_parity_next;
  logic       r_tx, w_tx_next, w_load;
  logic       w_bit_end, w_busy, w_accept;

  assign w_busy   = r_state inside {ST_START, ST_DATA, ST_PARITY, ST_STOP};
  assign w_accept = tx_valid && !r_hold_full;

  // Counter is held at zero outside a frame so the first bit gets its full width.
  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk_3125  (clk_3125),
    .i_rst     (rst),
    .i_restart (!w_busy),
    .o_bit_end (w_bit_end)
  );

  always_ff @(posedge clk_3125) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_parity    <= 1'b0;
      r_bit_cnt   <= '0;
      r_tx        <= 1'b1;
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_shift   <= w_shift_next;
      r_parity  <= w_parity_next;
      r_bit_cnt <= w_bit_cnt_next;
      r_tx      <= w_tx_next;
      if (w_load) begin
        r_hold_full <= 1'b0;
      end else if (w_accept) begin
        r_hold      <= tx_data;
        r_hold_full <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_shift_next   = r_shift;
    w_parity_next  = r_parity;
    w_bit_cnt_next = r_bit_cnt;
    w_tx_next      = r_tx;
    w_load         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_tx_next = 1'b1;
        w_load    = r_hold_full;
      end
      ST_START: begin
        if (w_bit_end) begin
          w_state_next   = ST_DATA;
          w_bit_cnt_next = '0;
          w_tx_next      = r_shift[7];
        end
      end
      ST_DATA: begin
        if (w_bit_end) begin
          w_bit_cnt_next = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'(DATA_BITS - 1)) begin
            w_state_next = ST_PARITY;
            w_tx_next    = r_parity;
          end else begin
            w_shift_next = {r_shift[6:0], 1'b0};
            w_tx_next    = r_shift[6];
          end
        end
      end
      ST_PARITY: begin
        if (w_bit_end) begin
          w_state_next = ST_STOP;
          w_tx_next    = 1'b1;
        end
      end
      ST_STOP: begin
        if (w_bit_end) begin
          w_state_next = ST_IDLE;
          w_load       = r_hold_full;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_tx_next    = 1'b1;
      end
    endcase
    // A queued byte chains straight into a start bit, from IDLE or the last stop cycle.
    if (w_load) begin
      w_state_next   = ST_START;
      w_shift_next   = r_hold;
      w_parity_next  = ^r_hold;
      w_bit_cnt_next = '0;
      w_tx_next      = 1'b0;
    end
  end

  assign tx       = r_tx;
  assign tx_ready = !r_hold_full;
  assign tx_busy  = w_busy;
  assign tx_done  = (r_state == ST_STOP) && w_bit_end;
  assign state    = r_state;

endmodule
